// File: rtl/seq_detector.sv
// Streaming sequence detector: flags every occurrence of PATTERN in a stream of
// SYM_W-bit symbols. Define SEQDET_NONOVERLAP_EN to restart matching after each hit.
module seq_detector #(
    parameter int                         SYM_W         = 2,
    parameter int                         SEQ_LEN       = 3,
    parameter logic [SEQ_LEN*SYM_W-1:0]   PATTERN       = {2'b01, 2'b10, 2'b11},
    parameter int                         CNT_W         = 8,
    parameter int                         FLUSH_ON_ZERO = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [SYM_W-1:0]               in_sym,
    output logic                           match,
    output logic                           found,
    output logic [CNT_W-1:0]               match_cnt,
    output logic [$clog2(SEQ_LEN+1)-1:0]   fill
);

    localparam int              HW   = SEQ_LEN * SYM_W;
    localparam int              FW   = $clog2(SEQ_LEN + 1);
    localparam logic [FW-1:0]   FULL = FW'(SEQ_LEN);
    localparam logic [FW-1:0]   LAST = FW'(SEQ_LEN - 1);

    // A zero pattern symbol could never match when zero is the flush symbol.
    genvar g;
    generate
        if (FLUSH_ON_ZERO != 0) begin : g_pat_chk
            for (g = 0; g < SEQ_LEN; g++) begin : g_sym
                if (PATTERN[g*SYM_W +: SYM_W] == '0) begin : g_bad
                    $error("seq_detector: PATTERN symbol %0d is zero while FLUSH_ON_ZERO=1", g);
                end
            end
        end
    endgenerate

    logic [HW-1:0]    hist;
    logic [HW-1:0]    hist_n;
    logic [HW-1:0]    hist_d;
    logic [FW-1:0]    fill_d;
    logic             found_d;
    logic             match_d;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;
    logic             flush;

    // Cast drops the oldest symbol; also covers SEQ_LEN=1 without a null slice.
    assign hist_n = HW'({hist, in_sym});
    assign flush  = (FLUSH_ON_ZERO != 0) && (in_sym == '0);

    always_comb begin
        hist_d  = hist;
        fill_d  = fill;
        found_d = found;
        cnt_d   = match_cnt;
        match_d = 1'b0;
        hit     = 1'b0;
        if (in_valid) begin
            if (flush) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d  = hist_n;
                fill_d  = (fill == FULL) ? FULL : fill + FW'(1);
                hit     = (fill >= LAST) && (hist_n == PATTERN);
                match_d = hit;
                if (hit) begin
                    found_d = 1'b1;
                    if (!(&match_cnt)) begin
                        cnt_d = match_cnt + CNT_W'(1);
                    end
`ifdef SEQDET_NONOVERLAP_EN
                    hist_d = '0;
                    fill_d = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            found     <= 1'b0;
            match_cnt <= '0;
        end else if (clear) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            found     <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist      <= hist_d;
            fill      <= fill_d;
            match     <= match_d;
            found     <= found_d;
            match_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: three configurations share one stimulus
// stream and are checked against a symbol-list reference model.
module tb_seq_detector;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_sym = 2'b00;

    always #5 clk = ~clk;

    logic       a_match, a_found, b_match, b_found, c_match, c_found;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt, c_cnt;
    logic [1:0] a_fill, b_fill, c_fill;

    // a: defaults; b: pattern 01,01 with 2-bit counter; c: default pattern, 2-bit counter
    seq_detector u_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sym(in_sym),
        .match(a_match), .found(a_found), .match_cnt(a_cnt), .fill(a_fill)
    );
    seq_detector #(.SEQ_LEN(2), .PATTERN(4'b0101), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sym(in_sym),
        .match(b_match), .found(b_found), .match_cnt(b_cnt), .fill(b_fill)
    );
    seq_detector #(.CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sym(in_sym),
        .match(c_match), .found(c_found), .match_cnt(c_cnt), .fill(c_fill)
    );

    typedef struct packed {
        logic [NI-1:0]      m;
        logic [NI-1:0]      f;
        logic [NI-1:0][7:0] c;
        logic [NI-1:0][1:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the symbols seen since the last flush/clear/reset/(hit).
    int mlen  [NI] = '{3, 2, 3};
    int mmax  [NI] = '{255, 3, 3};
    int mpat  [NI][3] = '{'{1, 2, 3}, '{1, 1, 0}, '{1, 2, 3}};
    int msyms [NI][$];
    int mcnt  [NI];
    bit mfound[NI];
    bit mmatch[NI];

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            msyms[i].delete();
            mcnt[i]   = 0;
            mfound[i] = 1'b0;
            mmatch[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(bit v, int s, bit clr);
        for (int i = 0; i < NI; i++) begin
            mmatch[i] = 1'b0;
            if (clr) begin
                msyms[i].delete();
                mcnt[i]   = 0;
                mfound[i] = 1'b0;
            end else if (v && s == 0) begin
                msyms[i].delete();
            end else if (v) begin
                bit ok;
                msyms[i].push_back(s);
                if (msyms[i].size() > mlen[i]) void'(msyms[i].pop_front());
                ok = (msyms[i].size() == mlen[i]);
                for (int k = 0; k < mlen[i] && ok; k++)
                    if (msyms[i][k] != mpat[i][k]) ok = 1'b0;
                if (ok) begin
                    mmatch[i] = 1'b1;
                    mfound[i] = 1'b1;
                    if (mcnt[i] < mmax[i]) mcnt[i]++;
`ifdef SEQDET_NONOVERLAP_EN
                    msyms[i].delete();
`endif
                end
            end
        end
    endfunction

    function automatic exp_t model_snapshot();
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            e.m[i]  = mmatch[i];
            e.f[i]  = mfound[i];
            e.c[i]  = 8'(mcnt[i]);
            e.fl[i] = 2'(msyms[i].size());
        end
        return e;
    endfunction

    task automatic step(input bit v, input logic [1:0] s, input bit clr);
        @(negedge clk);
        in_valid = v;
        in_sym   = s;
        clear    = clr;
        model_step(v, int'(s), clr);
        exp_q.push_back(model_snapshot());
    endtask

    task automatic sym(input logic [1:0] s);
        step(1'b1, s, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0);
    endtask

    // Reset asserted and released inside the low phase, away from either edge.
    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        idle();
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation per edge.
    initial begin
        exp_t e;
        int   am [NI];
        int   af [NI];
        int   ac [NI];
        int   afl[NI];
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                am  = '{int'(a_match), int'(b_match), int'(c_match)};
                af  = '{int'(a_found), int'(b_found), int'(c_found)};
                ac  = '{int'(a_cnt), int'(b_cnt), int'(c_cnt)};
                afl = '{int'(a_fill), int'(b_fill), int'(c_fill)};
                for (int i = 0; i < NI; i++) begin
                    chk("match", i, am[i], int'(e.m[i]));
                    chk("found", i, af[i], int'(e.f[i]));
                    chk("match_cnt", i, ac[i], int'(e.c[i]));
                    chk("fill", i, afl[i], int'(e.fl[i]));
                end
            end
        end
    end

    initial begin
        int budget;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle();

        // basic match
        sym(2'b01); sym(2'b10); sym(2'b11); idle();

        // repeated prefix, then zero flush breaks the second attempt
        async_reset();
        sym(2'b01); sym(2'b01); sym(2'b01); sym(2'b10); sym(2'b11);
        sym(2'b01); sym(2'b10); sym(2'b00); sym(2'b11); idle();

        // gaps in valid keep partial progress; then clear
        async_reset();
        sym(2'b01); idle(); idle(); idle(); sym(2'b10); idle(); sym(2'b11); idle();
        step(1'b0, 2'b00, 1'b1); idle();

        // overlapping pattern for the 01,01 instance
        sym(2'b01); sym(2'b01); sym(2'b01); sym(2'b01); idle();

        // reset mid-sequence discards progress
        step(1'b0, 2'b00, 1'b1);
        sym(2'b01); sym(2'b10);
        async_reset();
        sym(2'b11); idle();
        sym(2'b01); sym(2'b10); sym(2'b11); idle();

        // five matches back to back: saturation of the 2-bit counters
        step(1'b0, 2'b00, 1'b1);
        for (int n = 0; n < 5; n++) begin
            sym(2'b01); sym(2'b10); sym(2'b11);
        end
        idle();

        // random traffic biased toward pattern symbols
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                bit          v;
                bit          c;
                logic [1:0]  s;
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 79) == 0);
                s = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                step(v, s, c);
            end
        end
        idle();

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 0, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
